// File: rtl/line_buffer_pp.sv
// line_buffer_pp
// Ping-pong row collector. Incoming samples fill one bank as ROWS rows of
// LENGTH samples while the other bank holds a finished row set for the
// consumer. A frame begins at row iter_flag, so it carries
// (ROWS - iter) * LENGTH samples. Rows below iter are presented as zero.
//
// Ports
//   clk, reset            rising-edge clock; synchronous active-high reset
//   start, iter_flag      frame request and its first-row code (taken when busy=0)
//   in_data/in_valid/in_ready   sample stream; in_ready is high only while filling
//   busy                  a start would not be accepted this cycle
//   err                   one-cycle pulse after a start with iter_flag >= ROWS
//   out_rows, out_iter    row set and iteration code of the read bank (zero unless out_valid)
//   out_valid/out_ready   frame handshake; a handshake releases the read bank
module line_buffer_pp #(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 64,
    parameter int ROWS   = 3,
    parameter int IW     = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IW-1:0]    iter_flag,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             err,
    output logic [WIDTH-1:0] out_rows [0:ROWS-1][0:LENGTH-1],
    output logic [IW-1:0]    out_iter,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int CW = $clog2(LENGTH);
    localparam int RW = $clog2(ROWS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [0:0]       state;
    logic             wr_bank;
    logic             rd_bank;
    logic [1:0]       full;
    logic [IW-1:0]    bank_iter [0:1];
    // Frame counter kept as (row, column): row starts at iter, so the row
    // index is iter + counter/LENGTH without a divider.
    logic [RW-1:0]    row_q;
    logic [CW-1:0]    col_q;
    logic             err_q;

    logic [WIDTH-1:0] mem [0:1][0:ROWS-1][0:LENGTH-1];

    logic iter_ok;
    logic start_ok;
    logic beat;
    logic last_beat;
    logic release_rd;

    assign iter_ok    = ({1'b0, iter_flag} < (IW+1)'(ROWS));
    // busy comes from the registered full flag, so a release in the same
    // cycle does not let a start through until the next edge.
    assign busy       = (state == ST_FILL) || full[wr_bank];
    assign start_ok   = start && !busy;
    assign beat       = (state == ST_FILL) && in_valid;
    assign last_beat  = beat && (row_q == RW'(ROWS-1)) && (col_q == CW'(LENGTH-1));
    assign release_rd = full[rd_bank] && out_ready;

    assign in_ready  = (state == ST_FILL);
    assign err       = err_q;
    assign out_valid = full[rd_bank];
    assign out_iter  = out_valid ? bank_iter[rd_bank] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            full      <= 2'b00;
            bank_iter <= '{default: '0};
            row_q     <= '0;
            col_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= start_ok && !iter_ok;

            if (state == ST_IDLE) begin
                if (start_ok && iter_ok) begin
                    // The write bank is empty here, so its iter slot is free.
                    bank_iter[wr_bank] <= iter_flag;
                    row_q              <= RW'(iter_flag);
                    col_q              <= '0;
                    state              <= ST_FILL;
                end
            end else if (beat) begin
                if (col_q == CW'(LENGTH-1)) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
                if (last_beat) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    state         <= ST_IDLE;
                end
            end

            // A filling bank is never full and the read bank is, so a
            // completion and a release never target the same flag.
            if (release_rd) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

    // Sample storage: not reset, contents only reach the output while full.
    always_ff @(posedge clk) begin
        if (beat)
            mem[wr_bank][row_q][col_q] <= in_data;
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < LENGTH; c++) begin
                out_rows[r][c] = '0;
                if (out_valid && (r >= int'(bank_iter[rd_bank])))
                    out_rows[r][c] = mem[rd_bank][r][c];
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_pp.sv
module tb_line_buffer_pp;
    localparam int W  = 8;
    localparam int L  = 64;
    localparam int R  = 3;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [IW-1:0] iter_flag;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic          busy;
    logic          err;
    logic [W-1:0]  out_rows [0:R-1][0:L-1];
    logic [IW-1:0] out_iter;
    logic          out_valid;
    logic          out_ready;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: accepted samples in order, and iteration code per frame.
    logic [7:0] mdata [$];
    int         miter [$];

    line_buffer_pp #(.WIDTH(W), .LENGTH(L), .ROWS(R), .IW(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .iter_flag (iter_flag),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .busy      (busy),
        .err       (err),
        .out_rows  (out_rows),
        .out_iter  (out_iter),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nonzero_rows();
        int n = 0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < L; c++)
                if (out_rows[r][c] !== '0) n++;
        return n;
    endfunction

    task automatic do_start(input int it);
        int t = 0;
        while (busy && t < 2000) begin
            tick();
            t++;
        end
        chk("start_wait", {31'd0, busy}, 0);
        start     = 1'b1;
        iter_flag = IW'(it);
        tick();
        start = 1'b0;
        miter.push_back(it);
    endtask

    task automatic stream(input int n, input int base, input bit gaps);
        int k = 0;
        int t = 0;
        while (k < n && t < 20000) begin
            if (in_ready && (!gaps || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in_data  = 8'(base + k);
                mdata.push_back(in_data);
                k++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            t++;
        end
        in_valid = 1'b0;
        chk("stream_done", k, n);
    endtask

    task automatic check_frame(input string tag);
        int         it;
        int         bad = 0;
        logic [7:0] e;
        it = (miter.size() > 0) ? miter.pop_front() : -1;
        chk({tag, "_valid"}, {31'd0, out_valid}, 1);
        chk({tag, "_iter"}, {30'd0, out_iter}, it);
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < L; c++) begin
                if (r < it) e = 8'd0;
                else        e = (mdata.size() > 0) ? mdata.pop_front() : 8'hxx;
                if (out_rows[r][c] !== e) bad++;
            end
        end
        chk({tag, "_data"}, bad, 0);
    endtask

    task automatic release_frame();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; iter_flag = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_iter", {30'd0, out_iter}, 0);
        chk("rst_rows", nonzero_rows(), 0);

        // Full frame, iter 0, samples 0..191, held under backpressure.
        do_start(0);
        chk("f1_in_ready", {31'd0, in_ready}, 1);
        stream(192, 0, 1'b0);
        chk("f1_out_valid", {31'd0, out_valid}, 1);
        chk("f1_in_ready_done", {31'd0, in_ready}, 0);
        chk("f1_r1c0", out_rows[1][0], 64);
        chk("f1_r2c63", out_rows[2][63], 191);
        repeat (5) tick();
        chk("f1_hold_r2c63", out_rows[2][63], 191);
        chk("f1_hold_valid", {31'd0, out_valid}, 1);
        check_frame("f1");
        release_frame();
        chk("f1_released", {31'd0, out_valid}, 0);
        chk("f1_rel_rows", nonzero_rows(), 0);

        // iter 1: row 0 zero, 128 samples starting at 200 (wraps at 256).
        do_start(1);
        stream(128, 200, 1'b0);
        chk("f2_iter", {30'd0, out_iter}, 1);
        chk("f2_r0_zero", out_rows[0][0] | out_rows[0][63], 0);
        chk("f2_r1c0", out_rows[1][0], 200);
        chk("f2_r2c63", out_rows[2][63], 71);
        check_frame("f2");
        release_frame();

        // Two frames with no consumer: both banks full, third start blocked.
        do_start(2);
        stream(64, 10, 1'b0);
        do_start(0);
        stream(192, 90, 1'b0);
        chk("bp_busy", {31'd0, busy}, 1);
        start     = 1'b1;
        iter_flag = 2'd1;
        tick();
        chk("bp_blocked", {31'd0, in_ready}, 0);
        check_frame("fa");
        // Release with start still high: that start is not taken this edge.
        release_frame();
        chk("bp_same_edge", {31'd0, in_ready}, 0);
        chk("bp_busy_clear", {31'd0, busy}, 0);
        check_frame("fb");
        tick();
        start = 1'b0;
        chk("bp_accepted", {31'd0, in_ready}, 1);
        miter.push_back(1);
        stream(128, 40, 1'b0);
        release_frame();

        // Out-of-range iteration code.
        start     = 1'b1;
        iter_flag = 2'd3;
        tick();
        start = 1'b0;
        chk("err_pulse", {31'd0, err}, 1);
        chk("err_no_fill", {31'd0, in_ready}, 0);
        tick();
        chk("err_clear", {31'd0, err}, 0);
        chk("err_idle", {31'd0, in_ready}, 0);
        check_frame("fc");
        release_frame();

        // 20 frames, random gaps and backpressure.
        fork
            begin
                for (int f = 0; f < 20; f++) begin
                    int it;
                    it = $urandom_range(0, 2);
                    do_start(it);
                    stream((3 - it) * L, f * 37, 1'b1);
                end
            end
            begin
                int got = 0;
                int t   = 0;
                while (got < 20 && t < 60000) begin
                    @(negedge clk);
                    t++;
                    if (out_valid && $urandom_range(0, 2) == 0) begin
                        check_frame("rnd");
                        out_ready = 1'b1;
                        @(posedge clk);
                        #1;
                        out_ready = 1'b0;
                        got++;
                    end
                end
                chk("rnd_count", got, 20);
            end
        join
        chk("rnd_leftover", mdata.size(), 0);

        // Reset at beat 100 while the other bank is presented.
        do_start(2);
        stream(64, 5, 1'b0);
        do_start(0);
        stream(100, 120, 1'b0);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 0);
        chk("mid_rst_rows", nonzero_rows(), 0);
        chk("mid_rst_iter", {30'd0, out_iter}, 0);
        reset = 1'b0;
        mdata.delete();
        miter.delete();
        tick();
        chk("post_rst_busy", {31'd0, busy}, 0);
        do_start(1);
        stream(128, 77, 1'b0);
        check_frame("fpost");
        release_frame();
        chk("post_released", {31'd0, out_valid}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_buffer_pp.md
# line_buffer_pp

Parametrised, double-buffered (ping-pong) row collector for the wavelet transformer front end. It accepts a ready/valid stream of WIDTH-bit samples and assembles them into ROWS rows of LENGTH samples. The row count per frame is selected by an iteration code. While one bank presents a complete row set downstream under an out_valid/out_ready handshake, the other bank fills, so input continues without stalling.

## Interface
- WIDTH, 8, sample width in bits
- LENGTH, 64, samples per row (≥2)
- ROWS, 3, row slots per bank (≥2)
- IW, $clog2(ROWS), width of iteration code
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  frame request; sampled only when busy=0
- iter_flag  in  IW  iteration code, captured with start
- in_data  in  WIDTH  sample
- in_valid  in  1  sample present
- in_ready  out  1  sample accepted when in_valid && in_ready
- busy  out  1  start not accepted this cycle
- err  out  1  one-cycle pulse: start rejected (iter_flag ≥ ROWS)
- out_rows  out  ROWS×LENGTH×WIDTH  unpacked [0:ROWS-1][0:LENGTH-1] row set of read bank
- out_iter  out  IW  iteration code of presented frame
- out_valid  out  1  row set presented
- out_ready  in  1  consumer accepts frame

## Operation
- Two banks, each ROWS×LENGTH words, plus per-bank full flag and stored iter. Pointers wr_bank and rd_bank are 1 bit each, 0 after reset.
- Write FSM states:
  - IDLE: busy = full[wr_bank]. If start && !busy && iter_flag < ROWS, capture iter, set counter=0, go to FILL. If start && !busy && iter_flag ≥ ROWS, pulse err, stay in IDLE.
  - FILL: in_ready=1. Each accepted beat writes to bank[wr_bank], word index counter; counter increments. Row r = iter + counter/LENGTH, column = counter%LENGTH. Frame size N = (ROWS−iter)×LENGTH. On the accepted beat with counter==N−1: set full[wr_bank], store iter, toggle wr_bank, go to IDLE.
- Row placement: rows iter..ROWS−1 are filled in order. Rows 0..iter−1 of the frame are presented as zero. iter=0 fills all rows; iter=ROWS−1 fills only the last row.
- Read side: out_valid = full[rd_bank]. out_rows and out_iter come from bank rd_bank. Rows below out_iter are zero. All out_rows are zero when out_valid=0.
- On out_valid && out_ready: clear full[rd_bank] and toggle rd_bank.
- Simultaneous events:
  - Fill completion on one bank and release of the other in the same cycle both take effect.
  - A release of bank X in the cycle start is sampled does not unblock that start. busy uses the registered full flag, so the start is accepted next cycle.
- in_valid is ignored outside FILL. start is ignored in FILL.
- Counter width is $clog2(ROWS×LENGTH). It never wraps within a frame.
- Reset mid-frame: the partial frame is discarded and both banks are marked empty. Memory contents are not cleared; they are unobservable because out_rows is gated by out_valid.

## Timing
- Reset values: in_ready=0, busy=0, err=0, out_valid=0, out_iter=0, out_rows all zero, state IDLE, counter=0.
- Start accepted at edge T → in_ready=1 from T+1. The first sample can be accepted at edge T+1.
- Last beat accepted at edge E → out_valid=1 from E+1 if that bank is the read bank; in_ready=0 and state IDLE from E+1.
- Minimum frame period per bank: N+1 cycles (start cycle plus N beats), with in_valid held high.
- out_rows and out_iter are stable while out_valid && !out_ready.
- Release at edge R → next bank presented from R+1 if full. There are no bubbles between back-to-back full banks.
- Both banks full → busy=1 until the edge after a release.

## Test plan
- Reset, then start iter=0 and stream 0..191 (LENGTH=64, ROWS=3) with out_ready=0 → out_valid rises the cycle after beat 191; out_rows[1][0]=64, out_rows[2][63]=191; held stable.
- Start iter=1 and stream 128 samples → out_rows[0] all zero, out_rows[1][0]=first sample, out_rows[2][63]=last sample, out_iter=1.
- With out_ready=0, fill two frames → third start sees busy=1 and no in_ready; pulse out_ready for one cycle → second frame presented next cycle, busy=0 the cycle after, third frame proceeds.
- Start with iter_flag=3 (ROWS=3) → err=1 for one cycle, state stays IDLE, in_ready=0.
- Random in_valid gaps and out_ready backpressure over 20 frames with mixed iter → every frame matches the scoreboard and no sample is lost or duplicated.
- Assert reset at beat 100 of a frame while the other bank is presented → next cycle out_valid=0, out_rows zero, in_ready=0; a fresh frame afterwards is correct.
